// File: rtl/alu_ga_stim_gen.sv
// Chromosome-driven ALU stimulus generator: LFSR fields mapped through enabled range buckets.
// Optional runtime reseed ports are added when ALU_STIM_RESEED_EN is defined.
module alu_ga_stim_gen #(
  parameter int          DATA_WIDTH = 8,
  parameter int          A_RANGES   = 8,
  parameter int          B_RANGES   = 8,
  parameter int          DLY_RANGES = 4,
  parameter int          DLY_STEP   = 4,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [63:0] SEED       = 64'h1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [A_RANGES-1:0]   chrom_a_mask,
  input  logic [B_RANGES-1:0]   chrom_b_mask,
  input  logic [15:0]           chrom_op_mask,
  input  logic [DLY_RANGES-1:0] chrom_dly_mask,
  input  logic [CNT_WIDTH-1:0]  chrom_trans_cnt,
`ifdef ALU_STIM_RESEED_EN
  input  logic                  seed_we,
  input  logic [63:0]           seed_data,
`endif
  output logic [3:0]            tx_op,
  output logic [DATA_WIDTH-1:0] tx_a,
  output logic [DATA_WIDTH-1:0] tx_b,
  output logic                  tx_vld,
  input  logic                  tx_rdy,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  sent_cnt
);

  localparam int DW     = DATA_WIDTH;
  localparam int ABITS  = $clog2(A_RANGES);
  localparam int BBITS  = $clog2(B_RANGES);
  localparam int DSBITS = $clog2(DLY_STEP);
  localparam int DBITS  = $clog2(DLY_RANGES * DLY_STEP);
  localparam int MAXAB  = (A_RANGES > B_RANGES) ? A_RANGES : B_RANGES;
  localparam int MAXAD  = (MAXAB > DLY_RANGES) ? MAXAB : DLY_RANGES;
  localparam int MAXR   = (MAXAD > 16) ? MAXAD : 16;
  localparam int IDXW   = $clog2(MAXR);

  localparam logic [63:0]       SEED_INIT  = (SEED == 64'd0) ? 64'd1 : SEED;
  localparam logic [DW-1:0]     A_LOW_MASK = DW'((64'd1 << (DW - ABITS)) - 64'd1);
  localparam logic [DW-1:0]     B_LOW_MASK = DW'((64'd1 << (DW - BBITS)) - 64'd1);
  localparam logic [DBITS-1:0]  D_LOW_MASK = DBITS'(DLY_STEP - 1);

  typedef enum logic [1:0] {IDLE, GEN, DLY, SEND} state_t;

  state_t                state_reg, state_next;
  logic [63:0]           lfsr_reg, lfsr_next;
  logic [3:0]            op_reg, op_next;
  logic [DW-1:0]         a_reg, a_next;
  logic [DW-1:0]         b_reg, b_next;
  logic [DBITS-1:0]      dly_reg, dly_next;
  logic [CNT_WIDTH-1:0]  sent_reg, sent_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [A_RANGES-1:0]   am_reg, am_next;
  logic [B_RANGES-1:0]   bm_reg, bm_next;
  logic [15:0]           om_reg, om_next;
  logic [DLY_RANGES-1:0] dm_reg, dm_next;
  logic                  done_reg, done_next;

  // First enabled bucket at or after start, wrapping within n buckets (n is a power of 2).
  function automatic logic [IDXW-1:0] pick(input logic [MAXR-1:0] mask,
                                           input logic [IDXW-1:0] first,
                                           input int n);
    logic [MAXR-1:0] live;
    logic [IDXW-1:0] wrap, idx, sel;
    logic            found;
    wrap  = IDXW'(n - 1);
    live  = (mask == '0) ? '1 : mask;
    sel   = first & wrap;
    found = 1'b0;
    for (int k = 0; k < MAXR; k++) begin
      idx = (first + IDXW'(k)) & wrap;
      if (!found && (k < n) && live[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  logic [DW-1:0]    ra, rb;
  logic [3:0]       ro;
  logic [DBITS-1:0] rd;
  logic [IDXW-1:0]  a_idx, b_idx, op_idx, d_idx;
  logic [DW-1:0]    gen_a, gen_b;
  logic [DBITS-1:0] gen_dly;
  logic [CNT_WIDTH-1:0] sent_inc;

  always_comb begin
    ra      = lfsr_reg[DW-1:0];
    rb      = lfsr_reg[2*DW-1:DW];
    ro      = lfsr_reg[2*DW+3:2*DW];
    rd      = lfsr_reg[2*DW+4 +: DBITS];
    a_idx   = pick(MAXR'(am_reg), IDXW'(ra >> (DW - ABITS)), A_RANGES);
    b_idx   = pick(MAXR'(bm_reg), IDXW'(rb >> (DW - BBITS)), B_RANGES);
    op_idx  = pick(MAXR'(om_reg), IDXW'(ro), 16);
    d_idx   = pick(MAXR'(dm_reg), IDXW'(rd >> DSBITS), DLY_RANGES);
    gen_a   = (DW'(a_idx) << (DW - ABITS)) | (ra & A_LOW_MASK);
    gen_b   = (DW'(b_idx) << (DW - BBITS)) | (rb & B_LOW_MASK);
    gen_dly = (DBITS'(d_idx) << DSBITS) | (rd & D_LOW_MASK);
    sent_inc = sent_reg + CNT_WIDTH'(1);
  end

  always_comb begin
    state_next = state_reg;
    lfsr_next  = lfsr_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    dly_next   = dly_reg;
    sent_next  = sent_reg;
    cnt_next   = cnt_reg;
    am_next    = am_reg;
    bm_next    = bm_reg;
    om_next    = om_reg;
    dm_next    = dm_reg;
    done_next  = 1'b0;

    if (state_reg != IDLE) begin
      lfsr_next = {lfsr_reg[62:0], lfsr_reg[63] ^ lfsr_reg[62] ^ lfsr_reg[60] ^ lfsr_reg[59]};
    end
`ifdef ALU_STIM_RESEED_EN
    else if (seed_we) begin
      lfsr_next = (seed_data == 64'd0) ? 64'd1 : seed_data;
    end
`endif

    unique case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          am_next   = chrom_a_mask;
          bm_next   = chrom_b_mask;
          om_next   = chrom_op_mask;
          dm_next   = chrom_dly_mask;
          cnt_next  = chrom_trans_cnt;
          sent_next = '0;
          if (chrom_trans_cnt == '0) done_next  = 1'b1;
          else                        state_next = GEN;
        end
      end
      GEN: begin
        op_next    = 4'(op_idx);
        a_next     = gen_a;
        b_next     = gen_b;
        dly_next   = gen_dly;
        state_next = (gen_dly != '0) ? DLY : SEND;
      end
      DLY: begin
        dly_next = dly_reg - DBITS'(1);
        if (dly_reg == DBITS'(1)) state_next = SEND;
      end
      SEND: begin
        if (tx_rdy) begin
          sent_next = sent_inc;
          if (sent_inc == cnt_reg) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = GEN;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort wins over start and over a same-cycle handshake.
    if (abort) begin
      state_next = IDLE;
      done_next  = 1'b0;
      sent_next  = sent_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      lfsr_reg  <= SEED_INIT;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      dly_reg   <= '0;
      sent_reg  <= '0;
      cnt_reg   <= '0;
      am_reg    <= '0;
      bm_reg    <= '0;
      om_reg    <= '0;
      dm_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      lfsr_reg  <= lfsr_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      dly_reg   <= dly_next;
      sent_reg  <= sent_next;
      cnt_reg   <= cnt_next;
      am_reg    <= am_next;
      bm_reg    <= bm_next;
      om_reg    <= om_next;
      dm_reg    <= dm_next;
      done_reg  <= done_next;
    end
  end

  assign tx_op    = op_reg;
  assign tx_a     = a_reg;
  assign tx_b     = b_reg;
  assign tx_vld   = (state_reg == SEND);
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign sent_cnt = sent_reg;

endmodule

// File: tb/tb_alu_ga_stim_gen.sv
// Bench for alu_ga_stim_gen: transaction-level model of the bucket rules plus directed scenarios.
module tb_alu_ga_stim_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        tx_rdy = 1'b0;
  logic [7:0]  chrom_a_mask = 8'hff;
  logic [7:0]  chrom_b_mask = 8'hff;
  logic [15:0] chrom_op_mask = 16'hffff;
  logic [3:0]  chrom_dly_mask = 4'hf;
  logic [15:0] chrom_trans_cnt = 16'd0;
  logic [3:0]  tx_op;
  logic [7:0]  tx_a, tx_b;
  logic        tx_vld, busy, done;
  logic [15:0] sent_cnt;
`ifdef ALU_STIM_RESEED_EN
  logic        seed_we = 1'b0;
  logic [63:0] seed_data = 64'd0;
`endif

  always #5 clk = ~clk;

  alu_ga_stim_gen dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .chrom_a_mask(chrom_a_mask), .chrom_b_mask(chrom_b_mask),
    .chrom_op_mask(chrom_op_mask), .chrom_dly_mask(chrom_dly_mask),
    .chrom_trans_cnt(chrom_trans_cnt),
`ifdef ALU_STIM_RESEED_EN
    .seed_we(seed_we), .seed_data(seed_data),
`endif
    .tx_op(tx_op), .tx_a(tx_a), .tx_b(tx_b), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .busy(busy), .done(done), .sent_cnt(sent_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic        m_active = 1'b0;
  logic [63:0] m_q = 64'h1;
  int          m_gap = 0;
  int          m_sent = 0;
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [7:0]  m_am, m_bm;
  logic [15:0] m_om;
  logic [3:0]  m_dm;
  logic [3:0]  e_op;
  logic [7:0]  e_a, e_b;

  function automatic logic [63:0] lfsr_step(input logic [63:0] q);
    return {q[62:0], q[63] ^ q[62] ^ q[60] ^ q[59]};
  endfunction

  function automatic int pick_bucket(input int idx, input int n, input int mask);
    int live;
    int j;
    live = mask & ((1 << n) - 1);
    if (live == 0) live = (1 << n) - 1;
    for (int k = 0; k < n; k++) begin
      j = (idx + k) % n;
      if (live[j]) return j;
    end
    return idx;
  endfunction

  // Expected transaction and idle-gap length (GEN + delay cycles) from the current LFSR value.
  task automatic model_gen();
    int ra, rb, ro, rd, d;
    ra = int'(m_q[7:0]);
    rb = int'(m_q[15:8]);
    ro = int'(m_q[19:16]);
    rd = int'(m_q[23:20]);
    e_a  = 8'(pick_bucket(ra / 32, 8, int'(m_am)) * 32 + ra % 32);
    e_b  = 8'(pick_bucket(rb / 32, 8, int'(m_bm)) * 32 + rb % 32);
    e_op = 4'(pick_bucket(ro, 16, int'(m_om)));
    d    = pick_bucket(rd / 4, 4, int'(m_dm)) * 4 + rd % 4;
    m_gap = 1 + d;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_q      = 64'h1;
      m_gap    = 0;
      m_sent   = 0;
      m_cnt    = 0;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_q = lfsr_step(m_q);
        if (abort) m_active = 1'b0;
        else if (m_gap > 0) m_gap--;
        else if (tx_rdy) begin
          m_sent++;
          if (m_sent == m_cnt) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end else begin
            model_gen();
          end
        end
      end else if (start && !abort) begin
        m_am = chrom_a_mask;
        m_bm = chrom_b_mask;
        m_om = chrom_op_mask;
        m_dm = chrom_dly_mask;
        m_cnt = int'(chrom_trans_cnt);
        m_sent = 0;
        if (m_cnt == 0) m_done = 1'b1;
        else begin
          m_active = 1'b1;
          model_gen();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      chk("busy", busy, m_active);
      chk("tx_vld", tx_vld, m_active && (m_gap == 0));
      chk("done", done, m_done);
      chk("sent_cnt", sent_cnt, m_sent);
      if (m_active && m_gap == 0) begin
        chk("tx_op", tx_op, e_op);
        chk("tx_a", tx_a, e_a);
        chk("tx_b", tx_b, e_b);
      end
    end
  end

  // ---------------- monitors ----------------
  logic [7:0] hs_a [256];
  logic [7:0] hs_b [256];
  logic [3:0] hs_op[256];
  int hs_n = 0;
  int done_cnt = 0;
  int low_run = 0;
  int min_gap = 1000;
  int max_gap = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_vld && tx_rdy && !abort) begin
        if (hs_n < 256) begin
          hs_a[hs_n]  = tx_a;
          hs_b[hs_n]  = tx_b;
          hs_op[hs_n] = tx_op;
        end
        hs_n++;
        $display("tx %0d: op=%0d a=0x%02h b=0x%02h sent_cnt=%0d", hs_n, tx_op, tx_a, tx_b, sent_cnt);
      end
      if (done) done_cnt++;
      if (busy && !tx_vld) low_run++;
      else if (tx_vld && low_run > 0) begin
        if (low_run < min_gap) min_gap = low_run;
        if (low_run > max_gap) max_gap = low_run;
        low_run = 0;
      end else low_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    hs_n = 0;
    done_cnt = 0;
    min_gap = 1000;
    max_gap = 0;
  endtask

  task automatic pulse_start(input logic [15:0] cnt);
    chrom_trans_cnt = cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(name, seen, 1'b1);
  endtask

  task automatic wait_vld(input int budget, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tx_vld) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(name, seen, 1'b1);
  endtask

  task automatic all_masks();
    chrom_a_mask = 8'hff;
    chrom_b_mask = 8'hff;
    chrom_op_mask = 16'hffff;
    chrom_dly_mask = 4'hf;
  endtask

  initial begin
    logic [3:0] c_op;
    logic [7:0] c_a, c_b;
    logic [15:0] c_sent;
    logic seen7;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_vld", tx_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sent", sent_cnt, 0);
    chk("rst_tx_a", tx_a, 0);
    chk("rst_tx_b", tx_b, 0);
    chk("rst_tx_op", tx_op, 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    tick();

    // 200 transactions, all buckets enabled, driver always ready
    all_masks();
    tx_rdy = 1'b1;
    clear_mon();
    pulse_start(16'd200);
    wait_done(6000, "run200_done");
    tick();
    chk("run200_hs", hs_n, 200);
    chk("run200_sent", sent_cnt, 200);
    chk("run200_done_cnt", done_cnt, 1);
    // LFSR from seed 1 with rdy=1 and zero delays shifts the single bit by 2 per transaction
    chk("pin_a0", hs_a[0], 8'h01);
    chk("pin_a1", hs_a[1], 8'h04);
    chk("pin_a2", hs_a[2], 8'h10);
    chk("pin_a3", hs_a[3], 8'h40);
    chk("pin_b4", hs_b[4], 8'h01);
    chk("pin_op0", hs_op[0], 4'd0);

    // Zero-length run
    clear_mon();
    pulse_start(16'd0);
    chk("cnt0_done", done, 1);
    chk("cnt0_busy", busy, 0);
    chk("cnt0_vld", tx_vld, 0);
    tick();
    chk("cnt0_done_clear", done, 0);
    tick();
    chk("cnt0_done_cnt", done_cnt, 1);

    // Restricted masks: A bucket 2 only, op 0 only, delay bucket 0 only
    chrom_a_mask = 8'b0000_0100;
    chrom_b_mask = 8'h00;
    chrom_op_mask = 16'h0001;
    chrom_dly_mask = 4'b0001;
    clear_mon();
    pulse_start(16'd50);
    wait_done(600, "mask_done");
    tick();
    chk("mask_hs", hs_n, 50);
    for (int i = 0; i < 50; i++) begin
      chk("mask_a_bucket", hs_a[i][7:5], 3'b010);
      chk("mask_op", hs_op[i], 4'd0);
    end
    chk("mask_min_gap", min_gap, 1);
    chk("mask_max_gap_le4", max_gap <= 4, 1);

    // Back-pressure: rdy low for 10 cycles while valid, stray start ignored
    all_masks();
    tx_rdy = 1'b0;
    clear_mon();
    pulse_start(16'd5);
    wait_vld(40, "bp_vld_seen");
    c_op = tx_op;
    c_a = tx_a;
    c_b = tx_b;
    c_sent = sent_cnt;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      tick();
      chk("bp_vld_held", tx_vld, 1);
      chk("bp_a_stable", tx_a, c_a);
      chk("bp_b_stable", tx_b, c_b);
      chk("bp_op_stable", tx_op, c_op);
      chk("bp_sent_stable", sent_cnt, c_sent);
    end
    start = 1'b0;
    tx_rdy = 1'b1;
    wait_done(200, "bp_done");
    tick();
    chk("bp_sent", sent_cnt, 5);
    chk("bp_done_cnt", done_cnt, 1);

    // Abort after 7 of 20, then a full rerun
    clear_mon();
    pulse_start(16'd20);
    seen7 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (sent_cnt == 16'd7) begin
        seen7 = 1'b1;
        break;
      end
      tick();
    end
    chk("abort_reach7", seen7, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_vld", tx_vld, 0);
    chk("abort_sent", sent_cnt, 7);
    repeat (5) tick();
    chk("abort_no_done", done_cnt, 0);
    clear_mon();
    pulse_start(16'd20);
    wait_done(600, "rerun_done");
    tick();
    chk("rerun_sent", sent_cnt, 20);
    chk("rerun_hs", hs_n, 20);

    // Asynchronous reset while valid is asserted
    tx_rdy = 1'b0;
    pulse_start(16'd10);
    wait_vld(40, "rst_vld_seen");
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vld", tx_vld, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sent", sent_cnt, 0);
    chk("arst_a", tx_a, 0);
    chk("arst_b", tx_b, 0);
    chk("arst_op", tx_op, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    tx_rdy = 1'b1;
    clear_mon();
    pulse_start(16'd4);
    wait_done(100, "post_rst_done");
    tick();
    chk("post_rst_a0", hs_a[0], 8'h01);
    chk("post_rst_a1", hs_a[1], 8'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
